status_readback_module: RTL and testbench
=========================================

Name: status_readback_module

Overview:
Reader-side counterpart of the four-channel status writer. On request, it reads each channel's count word from the count BRAM region, then reads that many 64-bit status records from the channel's data region. Records are streamed out on a valid/ready interface tagged with channel and index. It sits between the BRAM read controller and the host/uplink packer and is triggered by the writer's threshold_reached level or by software.

Parameters:
DATA_BASE_ID0, 32'hC000_0000, channel 0 data region base
DATA_BASE_ID1, 32'hC001_0000, channel 1 data region base
DATA_BASE_ID2, 32'hC002_0000, channel 2 data region base
DATA_BASE_ID3, 32'hC003_0000, channel 3 data region base
COUNT_BASE_ID0, 32'hC100_0000, channel 0 count word address
COUNT_BASE_ID1, 32'hC101_0000, channel 1 count word address
COUNT_BASE_ID2, 32'hC102_0000, channel 2 count word address
COUNT_BASE_ID3, 32'hC103_0000, channel 3 count word address
MAX_RECORDS, 9'd256, per-channel clamp on the record count read back

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
dump_req  in  1  level; a rising edge starts a dump (threshold_reached or software)
busy  out  1  high whenever FSM is not IDLE
dump_done  out  1  one-cycle pulse when all four channels have been processed
cnt_ovf  out  1  sticky: some count exceeded MAX_RECORDS; cleared at next dump start
rd_start  out  1  read request, held high until rd_done
rd_addr  out  32  read byte address
rd_data  in  64  read data, valid in the rd_done cycle; count reads use [31:0]
rd_done  in  1  one-cycle read completion strobe
rec_valid  out  1  record available
rec_ready  in  1  downstream accept
rec_data  out  64  record payload
rec_ch  out  2  source channel
rec_idx  out  9  record index within channel, 0-based
rec_ch_last  out  1  marks the final record of the current channel
clear_counter  out  1  only with STATUS_RB_AUTO_CLEAR_EN; one-cycle pulse

Behaviour:
- Reset: FSM=IDLE. All outputs 0. rd_addr=COUNT_BASE_ID0. Internal ch=0, idx=0, count=0. dump_req edge detector register=0.
- States: IDLE, CNT_RD, DATA_RD, OUT, NEXT_CH, DONE.
- IDLE:
  - A rising edge of dump_req (registered edge detect) clears cnt_ovf and sets ch=0.
  - Next cycle: rd_start=1, rd_addr=COUNT_BASE_ID(ch), state CNT_RD.
  - A level held high without an edge starts nothing.
- CNT_RD:
  - Hold rd_start, rd_addr until rd_done.
  - On rd_done: rd_start=0; count = min(rd_data[31:0], MAX_RECORDS). If rd_data[31:0] > MAX_RECORDS, set cnt_ovf.
  - If count==0, go to NEXT_CH.
  - Otherwise idx=0, rd_addr=DATA_BASE_ID(ch), rd_start=1 next cycle, state DATA_RD.
- DATA_RD:
  - Hold until rd_done.
  - On rd_done: latch rd_data into rec_data; rec_valid=1, rec_ch=ch, rec_idx=idx, rec_ch_last=(idx==count-1); rd_start=0; state OUT.
- OUT:
  - Hold rec_* stable while rec_valid && !rec_ready.
  - On rec_valid && rec_ready: rec_valid=0.
  - If last, go to NEXT_CH.
  - Otherwise idx+1, rd_addr += 8 (32-bit wrap unchecked), rd_start=1, state DATA_RD.
  - At most one record is in flight; no read is issued until the previous record is accepted.
- NEXT_CH:
  - If ch==3, go to DONE.
  - Otherwise ch+1 and issue the count read for the new channel (rd_start=1), state CNT_RD.
- DONE: pulse dump_done for one cycle, return to IDLE.
- Minimum latency: dump_req edge to first rd_start = 2 cycles.
- rd_done outside CNT_RD/DATA_RD is ignored.
- dump_req edges while busy are ignored; they are not queued.
- rd_start never reasserts in the same cycle rd_done is seen.
- Async reset mid-dump aborts immediately to the reset state. A partial stream is acceptable; downstream discards it on busy fall without dump_done.
- Width rules: count is stored in 9 bits after clamp. idx compare uses 9 bits.

Optional Feature:
STATUS_RB_AUTO_CLEAR_EN:
- Defined: in DONE, clear_counter pulses high together with dump_done for exactly one cycle, re-arming the writer.
- Undefined: clear_counter is tied 0, and clearing is left to software.

Test Plan:
1. Count words 2,0,1,3, rec_ready always 1 -> 6 records: (ch0,idx0..1), (ch2,idx0), (ch3,idx0..2). Addresses C000_0000, C000_0008, C002_0000, C003_0000/08/10. rec_ch_last on ch0 idx1, ch2 idx0, ch3 idx2. One dump_done pulse; cnt_ovf=0.
2. All counts 0 -> exactly 4 count reads, no rec_valid, dump_done pulses, busy falls the cycle after.
3. Ch1 count 300, MAX_RECORDS=256 -> 256 ch1 records, last at idx 255; cnt_ovf=1 after dump. A following dump with count ≤256 clears cnt_ovf at its start.
4. Backpressure: rec_ready low for 5 cycles on each record -> rec_data, rec_idx, rec_ch stable while stalled; no rd_start while rec_valid is high.
5. dump_req toggled mid-dump; async rst_n pulsed during DATA_RD -> extra edge ignored. After reset: busy=0, rd_start=0, rec_valid=0, no dump_done. A new edge restarts from ch0.
6. With STATUS_RB_AUTO_CLEAR_EN, counts 1,1,1,1 -> clear_counter is one cycle high, coincident with dump_done. Without the macro, clear_counter stays 0.

Source files
------------

// File: rtl/status_readback_module_if.sv
// Read-controller request/response and record-stream signals of the status readback block.
// master = readback block, slave = BRAM read controller plus downstream packer.
interface status_readback_module_if;
  logic        rd_start;
  logic [31:0] rd_addr;
  logic [63:0] rd_data;
  logic        rd_done;
  logic        rec_valid;
  logic        rec_ready;
  logic [63:0] rec_data;
  logic [1:0]  rec_ch;
  logic [8:0]  rec_idx;
  logic        rec_ch_last;

  modport master (
    output rd_start, rd_addr, rec_valid, rec_data, rec_ch, rec_idx, rec_ch_last,
    input  rd_data, rd_done, rec_ready
  );
  modport slave (
    input  rd_start, rd_addr, rec_valid, rec_data, rec_ch, rec_idx, rec_ch_last,
    output rd_data, rd_done, rec_ready
  );
endinterface

// File: rtl/status_readback_module.sv
// Four-channel status readback: per channel, read the count word, then stream that many 64-bit records.
// Optional STATUS_RB_AUTO_CLEAR_EN: pulse clear_counter alongside dump_done to re-arm the writer.
module status_readback_module #(
  parameter logic [31:0] DATA_BASE_ID0  = 32'hC000_0000,
  parameter logic [31:0] DATA_BASE_ID1  = 32'hC001_0000,
  parameter logic [31:0] DATA_BASE_ID2  = 32'hC002_0000,
  parameter logic [31:0] DATA_BASE_ID3  = 32'hC003_0000,
  parameter logic [31:0] COUNT_BASE_ID0 = 32'hC100_0000,
  parameter logic [31:0] COUNT_BASE_ID1 = 32'hC101_0000,
  parameter logic [31:0] COUNT_BASE_ID2 = 32'hC102_0000,
  parameter logic [31:0] COUNT_BASE_ID3 = 32'hC103_0000,
  parameter logic [8:0]  MAX_RECORDS    = 9'd256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dump_req,
  output logic busy,
  output logic dump_done,
  output logic cnt_ovf,
  output logic clear_counter,
  status_readback_module_if.master bus
);

  typedef enum logic [2:0] {IDLE, CNT_RD, DATA_RD, OUT, NEXT_CH, DONE} state_t;

  state_t      state;
  logic        dump_q, dump_edge;
  logic [1:0]  ch;
  logic [8:0]  idx, count;
  logic        rd_start_q;
  logic [31:0] rd_addr_q;
  logic        rec_valid_q, rec_last_q;
  logic [63:0] rec_data_q;
  logic [1:0]  rec_ch_q;
  logic [8:0]  rec_idx_q;
  logic        dump_done_q, cnt_ovf_q;

  function automatic logic [31:0] count_base(input logic [1:0] c);
    case (c)
      2'd0:    return COUNT_BASE_ID0;
      2'd1:    return COUNT_BASE_ID1;
      2'd2:    return COUNT_BASE_ID2;
      default: return COUNT_BASE_ID3;
    endcase
  endfunction

  function automatic logic [31:0] data_base(input logic [1:0] c);
    case (c)
      2'd0:    return DATA_BASE_ID0;
      2'd1:    return DATA_BASE_ID1;
      2'd2:    return DATA_BASE_ID2;
      default: return DATA_BASE_ID3;
    endcase
  endfunction

  logic [31:0] cnt_word;
  logic        cnt_big;
  logic [8:0]  cnt_clamp;
  assign cnt_word  = bus.rd_data[31:0];
  assign cnt_big   = cnt_word > {23'd0, MAX_RECORDS};
  assign cnt_clamp = cnt_big ? MAX_RECORDS : cnt_word[8:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dump_q      <= 1'b0;
      dump_edge   <= 1'b0;
      ch          <= 2'd0;
      idx         <= 9'd0;
      count       <= 9'd0;
      rd_start_q  <= 1'b0;
      rd_addr_q   <= COUNT_BASE_ID0;
      rec_valid_q <= 1'b0;
      rec_last_q  <= 1'b0;
      rec_data_q  <= 64'd0;
      rec_ch_q    <= 2'd0;
      rec_idx_q   <= 9'd0;
      dump_done_q <= 1'b0;
      cnt_ovf_q   <= 1'b0;
    end else begin
      dump_q      <= dump_req;
      // Edges seen outside IDLE are dropped here so nothing is queued across a dump.
      dump_edge   <= dump_req & ~dump_q & (state == IDLE);
      dump_done_q <= 1'b0;
      unique case (state)
        IDLE: if (dump_edge) begin
          cnt_ovf_q  <= 1'b0;
          ch         <= 2'd0;
          rd_addr_q  <= COUNT_BASE_ID0;
          rd_start_q <= 1'b1;
          state      <= CNT_RD;
        end
        CNT_RD: if (bus.rd_done) begin
          rd_start_q <= 1'b0;
          count      <= cnt_clamp;
          if (cnt_big) cnt_ovf_q <= 1'b1;
          if (cnt_clamp == 9'd0) state <= NEXT_CH;
          else begin
            idx       <= 9'd0;
            rd_addr_q <= data_base(ch);
            state     <= DATA_RD;
          end
        end
        // Entered with rd_start low after a count read: raise it one cycle later.
        DATA_RD: if (!rd_start_q) rd_start_q <= 1'b1;
        else if (bus.rd_done) begin
          rd_start_q  <= 1'b0;
          rec_data_q  <= bus.rd_data;
          rec_valid_q <= 1'b1;
          rec_ch_q    <= ch;
          rec_idx_q   <= idx;
          rec_last_q  <= (idx == count - 9'd1);
          state       <= OUT;
        end
        OUT: if (bus.rec_ready) begin
          rec_valid_q <= 1'b0;
          if (rec_last_q) state <= NEXT_CH;
          else begin
            idx        <= idx + 9'd1;
            rd_addr_q  <= rd_addr_q + 32'd8;
            rd_start_q <= 1'b1;
            state      <= DATA_RD;
          end
        end
        NEXT_CH: if (ch == 2'd3) begin
          dump_done_q <= 1'b1;
          state       <= DONE;
        end else begin
          ch         <= ch + 2'd1;
          rd_addr_q  <= count_base(ch + 2'd1);
          rd_start_q <= 1'b1;
          state      <= CNT_RD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign dump_done       = dump_done_q;
  assign cnt_ovf         = cnt_ovf_q;
  assign bus.rd_start    = rd_start_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.rec_valid   = rec_valid_q;
  assign bus.rec_data    = rec_data_q;
  assign bus.rec_ch      = rec_ch_q;
  assign bus.rec_idx     = rec_idx_q;
  assign bus.rec_ch_last = rec_last_q;

`ifdef STATUS_RB_AUTO_CLEAR_EN
  assign clear_counter = dump_done_q;
`else
  assign clear_counter = 1'b0;
`endif

endmodule

// File: tb/tb_status_readback_module.sv
// Directed bench for status_readback_module: BRAM responder, record scoreboard, backpressure and reset cases.
module tb_status_readback_module;
  logic clk = 1'b0;
  logic rst_n, dump_req;
  logic busy, dump_done, cnt_ovf, clear_counter;

  status_readback_module_if bus();

  status_readback_module dut (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .busy(busy), .dump_done(dump_done),
    .cnt_ovf(cnt_ovf), .clear_counter(clear_counter), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [8:0]  idx;
    logic        last;
    logic [63:0] data;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] exp_rd[$];
  logic [31:0] rd_log[$];
  logic [31:0] cnt_w [4];
  int checks = 0, failures = 0;
  int done_cnt = 0, done_base = 0, clr_cnt = 0, clr_err = 0;
  bit bp_mode = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (a[31:24] == 8'hC1) return {32'hDEAD_BEEF, cnt_w[a[17:16]]};
    return {a, ~a};
  endfunction

  // BRAM read controller: fixed latency, one-cycle rd_done.
  initial begin
    int lat;
    lat = 0;
    bus.rd_done = 1'b0;
    bus.rd_data = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.rd_done = 1'b0;
        lat = 0;
      end else if (bus.rd_done) begin
        bus.rd_done = 1'b0;
        chk("rd_start_drop", bus.rd_start, 1'b0);
      end else if (bus.rd_start) begin
        if (lat == 2) begin
          bus.rd_done = 1'b1;
          bus.rd_data = mem_rd(bus.rd_addr);
          rd_log.push_back(bus.rd_addr);
          lat = 0;
        end else lat++;
      end else lat = 0;
    end
  end

  // Downstream sink + scoreboard compare.
  initial begin
    rec_t got, held_v, e;
    bit   held;
    int   stall;
    held = 1'b0;
    stall = 0;
    held_v = '0;
    bus.rec_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        stall = 0;
        continue;
      end
      if (dump_done) done_cnt++;
      if (clear_counter) clr_cnt++;
`ifdef STATUS_RB_AUTO_CLEAR_EN
      if (clear_counter !== dump_done) clr_err++;
`else
      if (clear_counter !== 1'b0) clr_err++;
`endif
      if (bus.rec_valid) begin
        got = {bus.rec_ch, bus.rec_idx, bus.rec_ch_last, bus.rec_data};
        chk("no_rd_while_valid", bus.rd_start, 1'b0);
        if (held) chk("stall_stable", got, held_v);
        if (bp_mode) begin
          bus.rec_ready = (stall >= 5);
          stall++;
        end else bus.rec_ready = 1'b1;
        if (bus.rec_ready) begin
          held = 1'b0;
          chk("rec_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rec", got, e);
          end
        end else begin
          held = 1'b1;
          held_v = got;
        end
      end else begin
        held = 1'b0;
        stall = 0;
        bus.rec_ready = !bp_mode;
      end
    end
  end

  task automatic start_dump(input logic [31:0] c0, c1, c2, c3);
    logic [31:0] a;
    int n;
    cnt_w[0] = c0; cnt_w[1] = c1; cnt_w[2] = c2; cnt_w[3] = c3;
    exp_rd.delete();
    rd_log.delete();
    done_base = done_cnt;
    for (int c = 0; c < 4; c++) begin
      exp_rd.push_back(32'hC100_0000 + (32'(c) << 16));
      n = (cnt_w[c] > 32'd256) ? 256 : int'(cnt_w[c]);
      for (int i = 0; i < n; i++) begin
        a = 32'hC000_0000 + (32'(c) << 16) + 32'(8 * i);
        exp_rd.push_back(a);
        exp_q.push_back({2'(c), 9'(i), (i == n - 1), a, ~a});
      end
    end
    @(negedge clk); dump_req = 1'b1;
    @(negedge clk);
    chk("lat_cyc1_rd_start", bus.rd_start, 1'b0);
    chk("lat_cyc1_busy", busy, 1'b0);
    @(negedge clk);
    chk("lat_cyc2_rd_start", bus.rd_start, 1'b1);
    chk("first_rd_addr", bus.rd_addr, 32'hC100_0000);
    chk("ovf_cleared_at_start", cnt_ovf, 1'b0);
    chk("busy_at_start", busy, 1'b1);
    dump_req = 1'b0;
  endtask

  task automatic finish_dump(input logic exp_ovf);
    int t;
    t = 0;
    while (dump_done !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", t < 20000, 1'b1);
    chk("busy_at_done", busy, 1'b1);
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
    chk("done_pulse_width", dump_done, 1'b0);
    chk("done_count", done_cnt - done_base, 1);
    chk("cnt_ovf", cnt_ovf, exp_ovf);
    chk("recs_left", exp_q.size(), 0);
    chk("rd_count", rd_log.size(), exp_rd.size());
    if (rd_log.size() == exp_rd.size())
      for (int i = 0; i < rd_log.size(); i++) chk("rd_addr_seq", rd_log[i], exp_rd[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d, c0;
    rst_n = 1'b0;
    dump_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_start", bus.rd_start, 1'b0);
    chk("rst_rd_addr", bus.rd_addr, 32'hC100_0000);
    chk("rst_rec_valid", bus.rec_valid, 1'b0);
    chk("rst_dump_done", dump_done, 1'b0);
    chk("rst_cnt_ovf", cnt_ovf, 1'b0);
    chk("rst_clear_counter", clear_counter, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // mixed counts
    start_dump(2, 0, 1, 3);
    finish_dump(1'b0);
    // all empty: four count reads only
    start_dump(0, 0, 0, 0);
    finish_dump(1'b0);
    // clamp on ch1, then exact-max dump clears the sticky flag
    start_dump(2, 300, 0, 1);
    finish_dump(1'b1);
    start_dump(1, 256, 0, 0);
    finish_dump(1'b0);
    // backpressure
    bp_mode = 1'b1;
    start_dump(2, 1, 0, 1);
    finish_dump(1'b0);
    bp_mode = 1'b0;

    // edges while busy are dropped; level alone does not restart
    start_dump(3, 3, 3, 3);
    repeat (12) @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk); dump_req = 1'b0;
    @(negedge clk); dump_req = 1'b1;
    finish_dump(1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("no_restart_on_level", busy, 1'b0);
    end
    dump_req = 1'b0;

    // async reset during a data read
    start_dump(3, 3, 3, 3);
    t = 0;
    while (!(bus.rd_start && bus.rd_addr[31:24] == 8'hC0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_data_rd", t < 2000, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_start", bus.rd_start, 1'b0);
    chk("midrst_rec_valid", bus.rec_valid, 1'b0);
    chk("midrst_dump_done", dump_done, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    d = done_cnt;
    repeat (4) @(negedge clk);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_rd_start", bus.rd_start, 1'b0);
    chk("postrst_no_done", done_cnt, d);
    start_dump(1, 0, 0, 2);
    finish_dump(1'b0);

    // clear_counter behaviour
    c0 = clr_cnt;
    start_dump(1, 1, 1, 1);
    finish_dump(1'b0);
`ifdef STATUS_RB_AUTO_CLEAR_EN
    chk("clear_pulses", clr_cnt - c0, 1);
`else
    chk("clear_pulses", clr_cnt - c0, 0);
`endif
    chk("clear_vs_done", clr_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
